// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, the ID/EX operand stage and the forwarding sources.
// The master drives decode/forwarding inputs; the slave is the operand stage.
interface id_ex_operand_stage_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          id_valid;
  logic [3:0]    id_opcode;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_use_imm;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [AW-1:0] id_rd_addr;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          stall;
  logic          flush;
  logic          exm_reg_write;
  logic [AW-1:0] exm_rd_addr;
  logic [DW-1:0] exm_result;
  logic          mwb_reg_write;
  logic [AW-1:0] mwb_rd_addr;
  logic [DW-1:0] mwb_result;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          load_use_hazard;

  modport master (
    output id_valid, id_opcode, id_rs_data, id_rt_data, id_imm, id_use_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_reg_write, id_mem_read,
           stall, flush, exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result,
    input  ex_valid, ex_opcode, alu_in1, alu_in2, ex_rd_addr,
           ex_reg_write, ex_mem_read, load_use_hazard
  );

  modport slave (
    input  id_valid, id_opcode, id_rs_data, id_rt_data, id_imm, id_use_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_reg_write, id_mem_read,
           stall, flush, exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result,
    output ex_valid, ex_opcode, alu_in1, alu_in2, ex_rd_addr,
           ex_reg_write, ex_mem_read, load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the 16-bit ALU with EX/MEM and MEM/WB operand
// forwarding, load-use bubble insertion, stall hold and branch flush.
module id_ex_operand_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic          valid_r;
  logic [3:0]    opcode_r;
  logic [DW-1:0] op1_r;
  logic [DW-1:0] op2_r;
  logic [AW-1:0] rs_addr_r;
  logic [AW-1:0] rt_addr_r;
  logic [AW-1:0] rd_addr_r;
  logic          use_imm_r;
  logic          reg_write_r;
  logic          mem_read_r;

  logic [DW-1:0] fwd1_s;
  logic [DW-1:0] fwd2_s;
  logic          hazard_s;

  // EX/MEM wins over MEM/WB; register 0 is never a forwarding target.
  function automatic logic [DW-1:0] fwd_sel(
    input logic          en,
    input logic [AW-1:0] src,
    input logic [DW-1:0] own,
    input logic          exm_we,
    input logic [AW-1:0] exm_rd,
    input logic [DW-1:0] exm_val,
    input logic          mwb_we,
    input logic [AW-1:0] mwb_rd,
    input logic [DW-1:0] mwb_val
  );
    logic [DW-1:0] res;
    if (en && exm_we && (exm_rd != {AW{1'b0}}) && (exm_rd == src)) begin
      res = exm_val;
    end else if (en && mwb_we && (mwb_rd != {AW{1'b0}}) && (mwb_rd == src)) begin
      res = mwb_val;
    end else begin
      res = own;
    end
    return res;
  endfunction

  // Forwarded operands; op2 is only forwarded when it came from rt.
  always_comb begin
    fwd1_s = fwd_sel(valid_r, rs_addr_r, op1_r,
                     bus.exm_reg_write, bus.exm_rd_addr, bus.exm_result,
                     bus.mwb_reg_write, bus.mwb_rd_addr, bus.mwb_result);
    fwd2_s = fwd_sel(valid_r & ~use_imm_r, rt_addr_r, op2_r,
                     bus.exm_reg_write, bus.exm_rd_addr, bus.exm_result,
                     bus.mwb_reg_write, bus.mwb_rd_addr, bus.mwb_result);
  end

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    hazard_s = bus.id_valid & valid_r & mem_read_r & (rd_addr_r != {AW{1'b0}}) &
               ((bus.id_rs_addr == rd_addr_r) |
                (~bus.id_use_imm & (bus.id_rt_addr == rd_addr_r)));
  end

  // Stage register: reset > flush > stall (with operand refresh) > bubble > capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      opcode_r    <= 4'h0;
      op1_r       <= {DW{1'b0}};
      op2_r       <= {DW{1'b0}};
      rs_addr_r   <= {AW{1'b0}};
      rt_addr_r   <= {AW{1'b0}};
      rd_addr_r   <= {AW{1'b0}};
      use_imm_r   <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
    end else if (bus.flush || (!bus.stall && hazard_s)) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
    end else if (bus.stall) begin
      // Keep values from producers that retire while we are frozen.
      op1_r <= fwd1_s;
      op2_r <= fwd2_s;
    end else begin
      valid_r     <= bus.id_valid;
      opcode_r    <= bus.id_opcode;
      op1_r       <= bus.id_rs_data;
      op2_r       <= bus.id_use_imm ? bus.id_imm : bus.id_rt_data;
      rs_addr_r   <= bus.id_rs_addr;
      rt_addr_r   <= bus.id_rt_addr;
      rd_addr_r   <= bus.id_rd_addr;
      use_imm_r   <= bus.id_use_imm;
      reg_write_r <= bus.id_valid & bus.id_reg_write;
      mem_read_r  <= bus.id_valid & bus.id_mem_read;
    end
  end

  assign bus.ex_valid        = valid_r;
  assign bus.ex_opcode       = opcode_r;
  assign bus.ex_rd_addr      = rd_addr_r;
  assign bus.ex_reg_write    = reg_write_r;
  assign bus.ex_mem_read     = mem_read_r;
  assign bus.alu_in1         = fwd1_s;
  assign bus.alu_in2         = fwd2_s;
  assign bus.load_use_hazard = hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: expectations are queued as stimulus
// is applied and drained against the outputs once the DUT has responded.
module tb_id_ex_operand_stage;

  localparam int S_VALID = 0;
  localparam int S_OPC   = 1;
  localparam int S_IN1   = 2;
  localparam int S_IN2   = 3;
  localparam int S_RD    = 4;
  localparam int S_RW    = 5;
  localparam int S_MR    = 6;
  localparam int S_HAZ   = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];

  id_ex_operand_stage_if #(.DW(16), .AW(4)) bus ();

  id_ex_operand_stage #(.DW(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_VALID: return {15'b0, bus.ex_valid};
      S_OPC:   return {12'b0, bus.ex_opcode};
      S_IN1:   return bus.alu_in1;
      S_IN2:   return bus.alu_in2;
      S_RD:    return {12'b0, bus.ex_rd_addr};
      S_RW:    return {15'b0, bus.ex_reg_write};
      S_MR:    return {15'b0, bus.ex_mem_read};
      S_HAZ:   return {15'b0, bus.load_use_hazard};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_fwd();
    bus.exm_reg_write = 1'b0;
    bus.exm_rd_addr   = 4'h0;
    bus.exm_result    = 16'h0000;
    bus.mwb_reg_write = 1'b0;
    bus.mwb_rd_addr   = 4'h0;
    bus.mwb_result    = 16'h0000;
  endtask

  task automatic issue(input logic [3:0] opc, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                       input logic [15:0] imm, input logic use_imm, input logic rw,
                       input logic mr);
    bus.id_valid     = 1'b1;
    bus.id_opcode    = opc;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_rd_addr   = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_use_imm   = use_imm;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clear_fwd();
    issue(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;

    // Power-on reset
    tick();
    tick();
    expect_v("rst_valid", S_VALID, 16'h0000);
    expect_v("rst_opc", S_OPC, 16'h0000);
    expect_v("rst_in1", S_IN1, 16'h0000);
    expect_v("rst_in2", S_IN2, 16'h0000);
    expect_v("rst_rd", S_RD, 16'h0000);
    expect_v("rst_rw", S_RW, 16'h0000);
    expect_v("rst_mr", S_MR, 16'h0000);
    check_out();
    rst_n = 1'b1;

    // Three instructions, then reset mid-stream
    issue(4'h0, 4'h1, 4'h2, 4'h3, 16'h0011, 16'h0022, 16'h0099, 1'b0, 1'b1, 1'b0);
    expect_v("i1_valid", S_VALID, 16'h0001);
    expect_v("i1_in1", S_IN1, 16'h0011);
    expect_v("i1_in2", S_IN2, 16'h0022);
    expect_v("i1_rd", S_RD, 16'h0003);
    expect_v("i1_rw", S_RW, 16'h0001);
    tick();
    check_out();
    issue(4'h5, 4'h6, 4'h2, 4'h7, 16'h0100, 16'h0022, 16'h00AB, 1'b1, 1'b1, 1'b0);
    expect_v("i2_opc", S_OPC, 16'h0005);
    expect_v("i2_in1", S_IN1, 16'h0100);
    expect_v("i2_in2_imm", S_IN2, 16'h00AB);
    tick();
    check_out();
    issue(4'h2, 4'h8, 4'h9, 4'hA, 16'h0202, 16'h0303, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    expect_v("mrst_valid", S_VALID, 16'h0000);
    expect_v("mrst_in1", S_IN1, 16'h0000);
    expect_v("mrst_in2", S_IN2, 16'h0000);
    expect_v("mrst_rw", S_RW, 16'h0000);
    tick();
    check_out();
    rst_n = 1'b1;

    // Forwarding: EX/MEM beats MEM/WB, then MEM/WB alone
    issue(4'h1, 4'h3, 4'h3, 4'h5, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    bus.id_valid      = 1'b0;
    bus.exm_reg_write = 1'b1;
    bus.exm_rd_addr   = 4'h3;
    bus.exm_result    = 16'h1234;
    bus.mwb_reg_write = 1'b1;
    bus.mwb_rd_addr   = 4'h3;
    bus.mwb_result    = 16'h5555;
    expect_v("fwd_exm_in1", S_IN1, 16'h1234);
    expect_v("fwd_exm_in2", S_IN2, 16'h1234);
    settle();
    check_out();
    bus.exm_reg_write = 1'b0;
    expect_v("fwd_mwb_in1", S_IN1, 16'h5555);
    expect_v("fwd_mwb_in2", S_IN2, 16'h5555);
    settle();
    check_out();
    clear_fwd();

    // Load-use: load to r4 in EX, consumer reads r4 as rs
    issue(4'h8, 4'h1, 4'h0, 4'h4, 16'h0040, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b1);
    expect_v("ld_mr", S_MR, 16'h0001);
    tick();
    check_out();
    issue(4'h2, 4'h4, 4'h0, 4'h6, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    expect_v("lu_haz_rs", S_HAZ, 16'h0001);
    settle();
    check_out();
    expect_v("lu_bubble_valid", S_VALID, 16'h0000);
    expect_v("lu_bubble_rw", S_RW, 16'h0000);
    expect_v("lu_bubble_mr", S_MR, 16'h0000);
    tick();
    check_out();
    issue(4'h8, 4'h1, 4'h0, 4'h4, 16'h0040, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b1);
    tick();
    issue(4'h2, 4'h1, 4'h4, 4'h6, 16'h0010, 16'h0000, 16'h0020, 1'b0, 1'b1, 1'b0);
    expect_v("lu_haz_rt", S_HAZ, 16'h0001);
    settle();
    check_out();
    bus.id_use_imm = 1'b1;
    expect_v("lu_imm_no_haz", S_HAZ, 16'h0000);
    settle();
    check_out();
    expect_v("lu_imm_valid", S_VALID, 16'h0001);
    expect_v("lu_imm_in2", S_IN2, 16'h0020);
    tick();
    check_out();

    // Stall with refresh: MEM/WB shows r2 = 0xBEEF in the first stall cycle only
    issue(4'h3, 4'h2, 4'h0, 4'h9, 16'h0000, 16'h0007, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    issue(4'hF, 4'h1, 4'h1, 4'hE, 16'hDEAD, 16'hDEAD, 16'h0000, 1'b0, 1'b1, 1'b0);
    bus.stall         = 1'b1;
    bus.mwb_reg_write = 1'b1;
    bus.mwb_rd_addr   = 4'h2;
    bus.mwb_result    = 16'hBEEF;
    expect_v("stall_c1_in1", S_IN1, 16'hBEEF);
    settle();
    check_out();
    tick();
    clear_fwd();
    expect_v("stall_c2_in1", S_IN1, 16'hBEEF);
    expect_v("stall_c2_in2", S_IN2, 16'h0007);
    expect_v("stall_c2_opc", S_OPC, 16'h0003);
    settle();
    check_out();
    tick();
    expect_v("stall_c3_in1", S_IN1, 16'hBEEF);
    check_out();
    tick();
    bus.stall = 1'b0;
    expect_v("stall_rel_in1", S_IN1, 16'hBEEF);
    expect_v("stall_rel_rd", S_RD, 16'h0009);
    settle();
    check_out();

    // Flush and stall together
    issue(4'h8, 4'h1, 4'h0, 4'h4, 16'h0040, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b1);
    tick();
    bus.id_valid = 1'b0;
    bus.stall    = 1'b1;
    bus.flush    = 1'b1;
    expect_v("flush_valid", S_VALID, 16'h0000);
    expect_v("flush_mr", S_MR, 16'h0000);
    tick();
    check_out();
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Register 0 is never forwarded
    issue(4'h1, 4'h0, 4'h0, 4'h1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    bus.id_valid      = 1'b0;
    bus.exm_reg_write = 1'b1;
    bus.exm_rd_addr   = 4'h0;
    bus.exm_result    = 16'hFFFF;
    bus.mwb_reg_write = 1'b1;
    bus.mwb_rd_addr   = 4'h0;
    bus.mwb_result    = 16'hAAAA;
    expect_v("r0_in1", S_IN1, 16'h0000);
    expect_v("r0_in2", S_IN2, 16'h0000);
    settle();
    check_out();
    clear_fwd();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
